// File: rtl/fetch_unit_if.sv
// Bus between the fetch unit and its surroundings: start request, decoder
// controls, and the PC/status outputs toward the instruction ROM and testbench.
interface fetch_unit_if #(
    parameter int PW = 10,
    parameter int OW = 5,
    parameter int CW = 16
);
    // Start is a level request with no ready: while it is high the unit keeps
    // reloading StartAddr. Ack is a level status that stays high from the halt
    // edge until the next Start or Reset. Neither side waits on the other.
    logic          Start;
    logic [PW-1:0] StartAddr;
    logic          BranchEn;
    logic          BranchOnFlag;
    logic          Done;
    logic          EqFlag;
    logic [OW-1:0] Offset;
    logic [PW-1:0] ProgCtr;
    logic          Running;
    logic          Ack;
    logic [CW-1:0] InstCount;
    logic [1:0]    dbg_state;

    modport master (
        input  Start, StartAddr, BranchEn, BranchOnFlag, Done, EqFlag, Offset,
        output ProgCtr, Running, Ack, InstCount, dbg_state
    );

    modport slave (
        output Start, StartAddr, BranchEn, BranchOnFlag, Done, EqFlag, Offset,
        input  ProgCtr, Running, Ack, InstCount, dbg_state
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and start/run/halt sequencer feeding the instruction ROM.
// Advances sequentially or by a signed relative offset on a taken branch.
module fetch_unit #(
    parameter int PW = 10,
    parameter int OW = 5,
    parameter int CW = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          taken;
    logic [PW-1:0] offset_sext;
    logic [CW-1:0] cnt_inc;

    assign taken       = bus.BranchEn & (bus.BranchOnFlag ? bus.EqFlag : ~bus.EqFlag);
    assign offset_sext = {{(PW-OW){bus.Offset[OW-1]}}, bus.Offset};
    // Retired-instruction count sticks at all-ones instead of wrapping.
    assign cnt_inc     = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (bus.Start) begin
            state_d = LOAD;
            pc_d    = bus.StartAddr;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LOAD: state_d = RUN;
                RUN: begin
                    cnt_d = cnt_inc;
                    if (bus.Done) begin
                        state_d = HALT;
                    end else if (taken) begin
                        pc_d = pc_q + offset_sext;
                    end else begin
                        pc_d = pc_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ProgCtr   = pc_q;
    assign bus.InstCount = cnt_q;
    assign bus.Running   = (state_q == RUN);
    assign bus.Ack       = (state_q == HALT);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, checked every
// cycle against an arithmetic model; a second instance uses a 4-bit counter.
module tb_fetch_unit;
    localparam int PW = 10;
    localparam int OW = 5;
    localparam int CW = 16;
    localparam int PC_MOD   = 1 << PW;
    localparam int CNT_MAX  = (1 << CW) - 1;
    localparam int CNT4_MAX = 15;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    fetch_unit_if #(.PW(PW), .OW(OW), .CW(CW)) bus ();
    fetch_unit_if #(.PW(PW), .OW(OW), .CW(4))  bus4 ();

    assign bus4.Start        = bus.Start;
    assign bus4.StartAddr    = bus.StartAddr;
    assign bus4.BranchEn     = bus.BranchEn;
    assign bus4.BranchOnFlag = bus.BranchOnFlag;
    assign bus4.Done         = bus.Done;
    assign bus4.EqFlag       = bus.EqFlag;
    assign bus4.Offset       = bus.Offset;

    fetch_unit #(.PW(PW), .OW(OW), .CW(CW)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    fetch_unit #(.PW(PW), .OW(OW), .CW(4)) u_dut4 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus4)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_pc   = 0;
    int m_cnt  = 0;
    int m_cnt4 = 0;
    int m_mode = M_IDLE;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_pc = 0; m_cnt = 0; m_cnt4 = 0; m_mode = M_IDLE;
        end else if (bus.Start === 1'b1) begin
            m_mode = M_LOAD;
            m_pc   = int'(bus.StartAddr);
            m_cnt  = 0;
            m_cnt4 = 0;
        end else if (m_mode == M_LOAD) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            int  off;
            bit  is_taken;
            off = int'(bus.Offset);
            if (off >= (1 << (OW - 1))) off = off - (1 << OW);
            is_taken = bus.BranchEn &&
                       ((bus.BranchOnFlag && bus.EqFlag) || (!bus.BranchOnFlag && !bus.EqFlag));
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (m_cnt4 < CNT4_MAX) m_cnt4 = m_cnt4 + 1;
            if (bus.Done) m_mode = M_HALT;
            else if (is_taken) m_pc = (m_pc + off + PC_MOD) % PC_MOD;
            else m_pc = (m_pc + 1) % PC_MOD;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge Clk) begin
        if (cmp_en) begin
            chk("pc",      32'(bus.ProgCtr),   32'(m_pc));
            chk("pc4",     32'(bus4.ProgCtr),  32'(m_pc));
            chk("cnt",     32'(bus.InstCount), 32'(m_cnt));
            chk("cnt4",    32'(bus4.InstCount), 32'(m_cnt4));
            chk("running", 32'(bus.Running),   32'(m_mode == M_RUN));
            chk("ack",     32'(bus.Ack),       32'(m_mode == M_HALT));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic clear_ctl();
        bus.BranchEn = 1'b0; bus.BranchOnFlag = 1'b0; bus.Done = 1'b0;
        bus.EqFlag = 1'b0; bus.Offset = '0;
    endtask

    // Start for one cycle, then drop it; returns in the first RUN cycle.
    task automatic launch(input logic [PW-1:0] addr);
        bus.Start = 1'b1; bus.StartAddr = addr;
        tick(1);
        bus.Start = 1'b0;
        tick(1);
    endtask

    task automatic branch(input logic bof, input logic eq, input logic [OW-1:0] off);
        bus.BranchEn = 1'b1; bus.BranchOnFlag = bof; bus.EqFlag = eq; bus.Offset = off;
        tick(1);
        clear_ctl();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.Start = 1'b0; bus.StartAddr = '0;
        clear_ctl();
        #1 Reset = 1'b1;
        tick(2);
        chk("rst_pc",      32'(bus.ProgCtr),   32'h0);
        chk("rst_cnt",     32'(bus.InstCount), 32'h0);
        chk("rst_running", 32'(bus.Running),   32'h0);
        chk("rst_ack",     32'(bus.Ack),       32'h0);
        cmp_en = 1'b1;
        Reset = 1'b0;
        tick(2);
        chk("idle_after_rst", 32'(bus.dbg_state), 32'h0);

        // Straight-line run from 0x040
        bus.Start = 1'b1; bus.StartAddr = 10'h040;
        tick(2);
        chk("load_pc",      32'(bus.ProgCtr), 32'h040);
        chk("load_running", 32'(bus.Running), 32'h0);
        bus.Start = 1'b0;
        tick(1);
        chk("run0_pc",  32'(bus.ProgCtr),   32'h040);
        chk("run0_run", 32'(bus.Running),   32'h1);
        chk("run0_cnt", 32'(bus.InstCount), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk("seq_pc",  32'(bus.ProgCtr),   32'h040 + 32'(i));
            chk("seq_cnt", 32'(bus.InstCount), 32'(i));
        end

        // beq taken backwards and not taken
        launch(10'h050);
        branch(1'b1, 1'b1, 5'b11100);
        chk("beq_taken_pc", 32'(bus.ProgCtr), 32'h04C);
        launch(10'h050);
        branch(1'b1, 1'b0, 5'b11100);
        chk("beq_not_taken_pc", 32'(bus.ProgCtr), 32'h051);

        // Wrap cases
        launch(10'h3FF);
        branch(1'b0, 1'b0, 5'd3);
        chk("bne_wrap_pc", 32'(bus.ProgCtr), 32'h002);
        launch(10'h3FF);
        tick(1);
        chk("seq_wrap_pc", 32'(bus.ProgCtr), 32'h000);
        launch(10'h001);
        branch(1'b1, 1'b1, 5'b11100);
        chk("neg_wrap_pc", 32'(bus.ProgCtr), 32'h3FD);
        launch(10'h0A0);
        branch(1'b1, 1'b1, 5'd0);
        chk("self_loop_pc",  32'(bus.ProgCtr),   32'h0A0);
        chk("self_loop_cnt", 32'(bus.InstCount), 32'd1);

        // Halt after ten retired instructions, then frozen under noise
        launch(10'h056);
        tick(10);
        chk("pre_halt_pc",  32'(bus.ProgCtr),   32'h060);
        chk("pre_halt_cnt", 32'(bus.InstCount), 32'd10);
        bus.Done = 1'b1;
        tick(1);
        chk("halt_ack", 32'(bus.Ack),       32'h1);
        chk("halt_run", 32'(bus.Running),   32'h0);
        chk("halt_pc",  32'(bus.ProgCtr),   32'h060);
        chk("halt_cnt", 32'(bus.InstCount), 32'd11);
        repeat (20) begin
            bus.Done = 1'($urandom_range(0, 1));
            bus.BranchEn = 1'($urandom_range(0, 1));
            bus.BranchOnFlag = 1'($urandom_range(0, 1));
            bus.EqFlag = 1'($urandom_range(0, 1));
            bus.Offset = OW'($urandom_range(0, 31));
            tick(1);
        end
        chk("frozen_pc",  32'(bus.ProgCtr),   32'h060);
        chk("frozen_cnt", 32'(bus.InstCount), 32'd11);
        chk("frozen_ack", 32'(bus.Ack),       32'h1);
        clear_ctl();

        // Restart from HALT, then abort mid-run with Start
        bus.Start = 1'b1; bus.StartAddr = 10'h200;
        tick(1);
        chk("restart_ack", 32'(bus.Ack), 32'h0);
        bus.Start = 1'b0;
        tick(4);
        chk("pre_abort_pc", 32'(bus.ProgCtr), 32'h203);
        bus.Start = 1'b1; bus.StartAddr = 10'h123;
        tick(1);
        chk("abort_pc",  32'(bus.ProgCtr),   32'h123);
        chk("abort_cnt", 32'(bus.InstCount), 32'd0);
        chk("abort_run", 32'(bus.Running),   32'h0);
        bus.Start = 1'b0;
        tick(5);
        chk("post_abort_pc", 32'(bus.ProgCtr), 32'h127);

        // Reset pulse between edges must act before the next edge
        #2 Reset = 1'b1;
        #1;
        chk("async_rst_pc",    32'(bus.ProgCtr),   32'h0);
        chk("async_rst_state", 32'(bus.dbg_state), 32'h0);
        chk("async_rst_run",   32'(bus.Running),   32'h0);
        chk("async_rst_cnt",   32'(bus.InstCount), 32'h0);
        Reset = 1'b0;
        tick(2);

        // Counter saturation on the 4-bit instance
        launch(10'h300);
        tick(20);
        chk("sat_cnt4", 32'(bus4.InstCount), 32'd15);
        chk("sat_cnt",  32'(bus.InstCount),  32'd20);
        chk("sat_pc",   32'(bus.ProgCtr),    32'h314);

        // Random traffic against the model
        repeat (400) begin
            bus.Start = ($urandom_range(0, 15) == 0);
            bus.StartAddr = PW'($urandom_range(0, PC_MOD - 1));
            bus.Done = ($urandom_range(0, 24) == 0);
            bus.BranchEn = 1'($urandom_range(0, 1));
            bus.BranchOnFlag = 1'($urandom_range(0, 1));
            bus.EqFlag = 1'($urandom_range(0, 1));
            bus.Offset = OW'($urandom_range(0, 31));
            tick(1);
        end
        bus.Start = 1'b0;
        clear_ctl();
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch sequencer that sits directly upstream of the control decoder. It holds the PC that addresses the instruction ROM and runs a start/run/halt state machine. Each run cycle it advances the PC sequentially or redirects it on a taken relative branch, using the decoder's BranchEn, BranchOnFlag and Done outputs and the compare flag. It also reports completion to the testbench and counts retired instructions.

## Interface
- PW, 10, PC width in bits (ROM depth 2^PW)
- OW, 5, branch offset width (Instruction[4:0]), two's complement
- CW, 16, retired-instruction counter width
- Clk  in  1  single clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  level request from testbench; while high, the block loads StartAddr
- StartAddr  in  PW  program entry address
- BranchEn  in  1  from decoder; current instruction is a conditional branch
- BranchOnFlag  in  1  from decoder; 1 = beq (taken when EqFlag=1), 0 = bne (taken when EqFlag=0)
- Done  in  1  from decoder; current instruction is halt
- EqFlag  in  1  registered compare flag from datapath
- Offset  in  OW  signed relative branch offset (Instruction[4:0])
- ProgCtr  out  PW  registered PC to instruction ROM address
- Running  out  1  high while in RUN
- Ack  out  1  high while in HALT (program finished)
- InstCount  out  CW  instructions retired in current run, saturating

## Operation
- States: IDLE, LOAD, RUN, HALT.
- Reset behaviour:
  - Reset → IDLE: ProgCtr=0, InstCount=0, Running=0, Ack=0.
  - Reset asserted mid-run aborts immediately (asynchronous).
- Start=1 in any state:
  - Next state LOAD. ProgCtr<=StartAddr, InstCount<=0.
  - Start has priority over Done and branch inputs.
- LOAD with Start=0 → RUN. ProgCtr holds StartAddr.
- RUN, each cycle, priority order:
  - Done=1 → HALT. ProgCtr holds (points at halt instruction). InstCount increments.
  - BranchEn=1 and taken → ProgCtr<=ProgCtr+sext(Offset), modulo 2^PW. InstCount increments.
  - Otherwise → ProgCtr<=ProgCtr+1, modulo 2^PW. InstCount increments.
- Taken condition: BranchEn & (BranchOnFlag ? EqFlag : ~EqFlag). Not-taken branch advances by 1.
- Offset=0 on a taken branch leaves PC unchanged (self-loop). This is legal, and InstCount still counts.
- PC wrap: address 2^PW−1 plus 1 gives 0. Negative offsets below 0 wrap likewise.
- InstCount saturates at 2^CW−1; no wrap.
- HALT: ProgCtr, InstCount frozen. Done/BranchEn ignored. Exit only via Start or Reset.
- IDLE: ProgCtr, InstCount hold; Done/BranchEn ignored.
- Running = (state==RUN); Ack = (state==HALT); both derived from the state register, no combinational path from inputs.

## Timing
- ProgCtr is registered. ROM read and decode are combinational within the cycle; PC update lands on the next edge.
- Branch redirect latency is 1 cycle, with no delay slot and no bubble.
- Start low → first instruction (StartAddr) is executed in the first RUN cycle, one edge after Start falls.
- Halt edge:
  - Ack rises one edge after the cycle in which Done=1 was presented in RUN.
  - Running falls on the same edge.
- Start rising in HALT: Ack falls at the next edge.
- Reset deassertion with Start=0: stays in IDLE.

## Test plan
- Reset, then Start=1 for 2 cycles with StartAddr=0x040, then Start=0, no branches:
  - ProgCtr=0x040, then 0x041, 0x042, … one per cycle.
  - Running=1; InstCount counts 1, 2, 3.
- In RUN at PC=0x050, BranchEn=1, BranchOnFlag=1, EqFlag=1, Offset=5'b11100 (−4) → next PC=0x04C.
  - Same instruction with EqFlag=0 → next PC=0x051.
- bne at PC=0x3FF: BranchOnFlag=0, EqFlag=0, Offset=+3 → next PC=0x002 (wrap).
  - Sequential step from 0x3FF → 0x000.
- Done=1 at PC=0x060 after 10 retired instructions:
  - Next edge: Ack=1, Running=0, ProgCtr=0x060, InstCount=11.
  - Both stay frozen for 20 cycles with random branch inputs.
- Abort cases:
  - Start=1 mid-RUN → LOAD, ProgCtr=StartAddr, InstCount=0.
  - Reset pulse between edges mid-RUN → ProgCtr=0, state IDLE immediately, before the next edge.
- CW=4 override, 20-instruction straight-line run → InstCount saturates at 15.
